// File: rtl/capture_timer_if.sv
// rtl/capture_timer_if.sv - register bus and interrupt between the CPU and the capture timer
interface capture_timer_if;
  logic        en;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        irq;

  modport master (
    output en, wr_en, addr, data_in,
    input  data_out, irq
  );

  modport slave (
    input  en, wr_en, addr, data_in,
    output data_out, irq
  );
endinterface

// File: rtl/capture_timer.sv
// rtl/capture_timer.sv - prescaled 16-bit tick counter with edge timestamp capture FIFO
module capture_timer #(
  parameter int CLOCK_FREQUENCY  = 50_000_000,
  parameter int TICKS_PER_SECOND = 1000,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic            clk,
  input  logic            rst,
  capture_timer_if.slave  bus,
  input  logic            capture_in
);

  localparam int COUNT = CLOCK_FREQUENCY / TICKS_PER_SECOND - 1;
  localparam int PRE_W = (COUNT > 0) ? $clog2(COUNT + 1) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PRE_W-1:0] prescaler;
  logic [15:0]      ticks;
  logic             cap_en;
  logic             edge_sel;
  logic             irq_en;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             irq;

  logic             wr_strobe;
  logic             tick_load;
  logic             ctrl_write;
  logic             clr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             edge_det;
  logic             push_req;
  logic             push;
  logic             drop;
  logic [15:0]      rdata;

  always_comb begin
    wr_strobe  = bus.en & bus.wr_en;
    tick_load  = wr_strobe && (bus.addr == 2'd2);
    ctrl_write = wr_strobe && (bus.addr == 2'd1);
    clr        = ctrl_write && bus.data_in[2];
    empty      = (count == '0);
    full       = (count == CNT_W'(FIFO_DEPTH));
    pop        = wr_strobe && (bus.addr == 2'd0) && !empty;
    edge_det   = edge_sel ? (~sync2 & prev) : (sync2 & ~prev);
    push_req   = edge_det & cap_en;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      ticks     <= '0;
    end else if (tick_load) begin
      prescaler <= '0;
      ticks     <= bus.data_in;
    end else if (prescaler == PRE_W'(COUNT)) begin
      prescaler <= '0;
      ticks     <= ticks + 16'd1;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= capture_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_en   <= 1'b0;
      edge_sel <= 1'b0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_write) begin
        cap_en   <= bus.data_in[0];
        edge_sel <= bus.data_in[1];
        irq_en   <= bus.data_in[3];
      end
      irq <= irq_en & ~empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      // The clear strobe overrides any push or pop landing in the same cycle.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ticks;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (drop) ovf <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      2'd0: rdata = empty ? 16'h0000 : mem[rd_ptr];
      2'd1: rdata = {ovf, 7'b0, 7'(count), empty};
      2'd2: rdata = ticks;
      2'd3: rdata = {12'b0, irq_en, 1'b0, edge_sel, cap_en};
      default: rdata = '0;
    endcase
  end

  assign bus.data_out = rdata;
  assign bus.irq      = irq;

endmodule

// File: tb/tb_capture_timer.sv
// tb/tb_capture_timer.sv - directed self-checking bench for capture_timer
module tb_capture_timer;
  logic clk = 1'b0;
  logic rst;
  logic capture_in;
  int   checks = 0;
  int   errors = 0;

  capture_timer_if bus();

  capture_timer #(
    .CLOCK_FREQUENCY(10),
    .TICKS_PER_SECOND(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .capture_in(capture_in)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the write is taken at the following posedge.
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    bus.en      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    @(negedge clk);
    bus.en      = 1'b0;
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
    bus.addr = a;
    #1;
    d = bus.data_out;
  endtask

  task automatic test_reset;
    logic [15:0] rd;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), rd);
      checks++;
      if (rd !== ((i == 1) ? 16'h0001 : 16'h0000)) begin
        errors++;
        $display("FAIL reset_reg%0d got %h exp %h", i, rd, (i == 1) ? 16'h0001 : 16'h0000);
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b exp 0", bus.irq);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_tick_count;
    logic [15:0] rd;
    repeat (35) @(negedge clk);
    read_reg(2'd2, rd);
    checks++;
    if (rd !== 16'h0003) begin
      errors++;
      $display("FAIL tick_35clk got %h exp 0003", rd);
    end
    @(negedge clk);
    bus_write(2'd2, 16'hFFFF);
    repeat (9) @(negedge clk);
    read_reg(2'd2, rd);
    checks++;
    if (rd !== 16'hFFFF) begin
      errors++;
      $display("FAIL tick_before_wrap got %h exp ffff", rd);
    end
    @(negedge clk);
    read_reg(2'd2, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("FAIL tick_wrap got %h exp 0000", rd);
    end
  endtask

  task automatic test_single_capture;
    logic [15:0] rd;
    @(negedge clk);
    bus_write(2'd1, 16'h0009);
    bus_write(2'd2, 16'h0100);
    capture_in = 1'b1;
    repeat (3) @(negedge clk);
    read_reg(2'd0, rd);
    checks++;
    if (rd !== 16'h0100) begin
      errors++;
      $display("FAIL single_stamp got %h exp 0100", rd);
    end
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("FAIL single_status got %h exp 0002", rd);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL single_irq_early got %b exp 0", bus.irq);
    end
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL single_irq got %b exp 1", bus.irq);
    end
    bus_write(2'd0, 16'h0000);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL single_pop_status got %h exp 0001", rd);
    end
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL single_irq_clear got %b exp 0", bus.irq);
    end
    capture_in = 1'b0;
    repeat (4) @(negedge clk);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL rising_ignores_fall got %h exp 0001", rd);
    end
  endtask

  task automatic test_edge_select;
    logic [15:0] rd;
    @(negedge clk);
    bus_write(2'd1, 16'h0003);
    read_reg(2'd3, rd);
    checks++;
    if (rd !== 16'h0003) begin
      errors++;
      $display("FAIL ctrl_readback got %h exp 0003", rd);
    end
    capture_in = 1'b1;
    repeat (4) @(negedge clk);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL falling_ignores_rise got %h exp 0001", rd);
    end
    capture_in = 1'b0;
    repeat (3) @(negedge clk);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("FAIL falling_push got %h exp 0002", rd);
    end
    @(negedge clk);
    bus_write(2'd0, 16'h0000);
    bus_write(2'd1, 16'h0002);
    capture_in = 1'b1;
    repeat (4) @(negedge clk);
    capture_in = 1'b0;
    repeat (4) @(negedge clk);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL cap_disabled got %h exp 0001", rd);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] rd;
    logic [15:0] exp;
    @(negedge clk);
    bus_write(2'd1, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      bus_write(2'd2, 16'(16'h0010 + i));
      capture_in = 1'b1;
      repeat (3) @(negedge clk);
      capture_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h8008) begin
      errors++;
      $display("FAIL ovf_status got %h exp 8008", rd);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 16'(16'h0010 + i);
      @(negedge clk);
      read_reg(2'd0, rd);
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL ovf_entry%0d got %h exp %h", i, rd, exp);
      end
      @(negedge clk);
      bus_write(2'd0, 16'h0000);
    end
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h8001) begin
      errors++;
      $display("FAIL ovf_sticky got %h exp 8001", rd);
    end
    @(negedge clk);
    bus_write(2'd1, 16'h0005);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL clr_status got %h exp 0001", rd);
    end
    read_reg(2'd3, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL clr_not_stored got %h exp 0001", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      capture_in = 1'b1;
      repeat (3) @(negedge clk);
      capture_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0008) begin
      errors++;
      $display("FAIL full_status got %h exp 0008", rd);
    end
    @(negedge clk);
    capture_in = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(2'd0, 16'h0000);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0008) begin
      errors++;
      $display("FAIL pop_push_full got %h exp 0008", rd);
    end
    @(negedge clk);
    capture_in = 1'b0;
    repeat (3) @(negedge clk);
    capture_in = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(2'd1, 16'h0005);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL clr_wins got %h exp 0001", rd);
    end
    @(negedge clk);
    capture_in = 1'b0;
    repeat (3) @(negedge clk);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL clr_event_lost got %h exp 0001", rd);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] rd;
    @(negedge clk);
    bus_write(2'd1, 16'h0009);
    bus_write(2'd2, 16'h1234);
    for (int i = 0; i < 2; i++) begin
      capture_in = 1'b1;
      repeat (3) @(negedge clk);
      capture_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL midrun_irq got %b exp 1", bus.irq);
    end
    capture_in = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), rd);
      checks++;
      if (rd !== ((i == 1) ? 16'h0001 : 16'h0000)) begin
        errors++;
        $display("FAIL midrun_reg%0d got %h exp %h", i, rd, (i == 1) ? 16'h0001 : 16'h0000);
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL midrun_irq_clear got %b exp 0", bus.irq);
    end
    capture_in = 1'b0;
    repeat (5) @(negedge clk);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin
      errors++;
      $display("FAIL midrun_no_capture got %h exp 0001", rd);
    end
  endtask

  initial begin
    rst         = 1'b1;
    capture_in  = 1'b0;
    bus.en      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = 2'd0;
    bus.data_in = 16'h0000;
    test_reset;
    test_tick_count;
    test_single_capture;
    test_edge_select;
    test_overflow;
    test_back_to_back;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
